video_line_buffer_pp: RTL and testbench
=======================================

Name: video_line_buffer_pp

Overview:
Parametrised, double-banked (ping-pong) row buffer between the VRAM/video-decoder write path and the pixel output. One bank fills while the other is scanned out. Supports configurable colour depth and pixel packing, native or 2x horizontal pixel doubling, per-bank valid tracking, and underrun detection with blank-colour substitution. Runs on the single master clock with a pixel clock-enable, so no clock-domain crossing is needed.

Parameters:
COLOR_BITS, 4, bits per colour channel (C); pixel width P = 3*C
PIXELS_PER_WORD, 2, pixels packed per memory word; power of two (1, 2, 4); W = P*PIXELS_PER_WORD
ADDR_BITS, 9, word address width; each bank holds 2^ADDR_BITS words
BLANK_RGB, {blue=0, green=0, red=all ones}, P-bit colour driven during blank, underrun or mode 0

Ports:
i_master_clk  in  1  clock; all logic on rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_pixel_ce  in  1  pixel clock enable; the read pipeline advances only when high
i_scale_mode  in  2  0 = blank, 1 = native, 2 = 2x horizontal doubling, 3 = reserved (treated as 0)
i_line_swap  in  1  one-cycle pulse: swap read and write banks
i_fill_start  in  1  one-cycle pulse: clear the write bank's valid flag
i_fill_done  in  1  one-cycle pulse: set the write bank's valid flag
i_wr_column  in  ADDR_BITS  write word address
i_wr_data  in  W  packed pixels; pixel k at [k*P +: P]; within a pixel red is LSBs, then green, then blue
i_wr_valid  in  1  write strobe into the write bank
i_pixel_first  in  1  first visible pixel of the line (qualified by i_pixel_ce)
i_pixel_last  in  1  last visible pixel of the line (qualified by i_pixel_ce)
i_blank  in  1  timing blank (qualified by i_pixel_ce)
i_clear_status  in  1  clears o_underrun
o_red, o_green, o_blue  out  C each  pixel colour
o_pixel_valid  out  1  high while outputs carry active-line pixels
o_wr_bank  out  1  index of the bank currently being written
o_underrun  out  1  sticky underrun flag

Behaviour:
- Reset (async assert, sync release):
  - read bank = 0, write bank = 1 (o_wr_bank = 1).
  - Both valid flags = 0; counter = 0; active = 0.
  - All colour outputs = 0; o_pixel_valid = 0; o_underrun = 0.
  - Reset mid-line aborts the line immediately.
- Write side (every clock, independent of i_pixel_ce):
  - i_wr_valid writes i_wr_data to memory[write bank][i_wr_column].
  - Writes are accepted whether or not a fill is open. Read and write always target different banks, so there is no collision.
- Valid flags:
  - i_fill_start clears the write bank's flag; i_fill_done sets it.
  - If both arrive in the same cycle, i_fill_done wins.
- Bank swap:
  - i_line_swap while not active: swap on the next clock.
  - i_line_swap while active: remembered as pending and applied on the clock after the ce that samples i_pixel_last.
  - i_fill_start or i_fill_done in the same cycle as an applied swap acts on the new write bank.
  - A second swap while one is pending is dropped.
- Read counter (when i_pixel_ce):
  - i_pixel_first: counter = 0, active = 1.
  - Otherwise, if active: counter += 1.
  - i_pixel_last: active = 0 after that pixel.
  - The counter has ADDR_BITS + log2(PIXELS_PER_WORD) + 1 bits and wraps silently.
- Address and sub-pixel selection, with S = log2(PIXELS_PER_WORD):
  - Mode 1: word = counter >> S; sub-pixel = counter[S-1:0].
  - Mode 2: word = counter >> (S+1); sub-pixel = counter[S:1].
  - Address bits beyond ADDR_BITS are truncated.
- Line snapshot: the line-underrun bit is latched at the ce sampling i_pixel_first. It is set if the read bank's valid flag is 0 and the mode is 1 or 2; that same event sets o_underrun.
- Pipeline (ce-qualified):
  - Stage 1: registered memory read, plus delayed sub-pixel, blank and active.
  - Stage 2: output register.
  - Latency is exactly 2 ce cycles from the pixel_first sample to the first pixel on the outputs. Outputs hold between ces.
- Output colour:
  - BLANK_RGB if the delayed i_blank is high, the mode is 0 or 3, or the line-underrun bit is set.
  - Otherwise the selected pixel.
  - o_pixel_valid = delayed active.
- o_underrun clears on i_clear_status; if set and clear occur in the same cycle, set wins.

Test Plan:
- Reset: pulse i_reset_n low mid-line -> outputs 0, o_pixel_valid 0, o_wr_bank 1; line aborted.
- Mode 1, C=4, PPW=2: fill words 0..3 with 24'h{3k+2,3k+1,3k} style data, fill_done, swap, then 8 ce pixels -> colours emitted in order, red of word 0 pixel 0 first, exactly 2 ces after pixel_first.
- Mode 2: same data -> each pixel repeated twice; 8 pixels consume words 0..1 only.
- Underrun: swap without fill_done, then start a line -> every pixel = BLANK_RGB (red 4'hf), o_underrun=1; i_clear_status -> 0.
- Swap mid-line: i_line_swap at pixel 3 of 8 -> o_wr_bank unchanged until the clock after the pixel_last ce, then toggles; the line reads the old bank throughout.
- i_pixel_ce duty 1/3 with i_blank pulsed over pixels 2..3 -> outputs stable between ces; those pixels = BLANK_RGB.

Source files
------------

// File: rtl/video_line_buffer_pp.sv
// ============================================================================
// video_line_buffer_pp
// ----------------------------------------------------------------------------
// Ping-pong line buffer between the video write path and the pixel output.
// One bank is filled by the write side while the other is scanned out. The
// read pipeline runs on i_master_clk qualified by i_pixel_ce, giving exactly
// two ce cycles from the pixel_first sample to the first pixel on the outputs.
//
// Ports:
//   i_master_clk    master clock, all logic on the rising edge
//   i_reset_n       asynchronous active-low reset
//   i_pixel_ce      pixel clock enable for the read pipeline
//   i_scale_mode    0 blank, 1 native, 2 horizontal 2x, 3 treated as blank
//   i_line_swap     swap read/write banks (deferred to end of an active line)
//   i_fill_start    clear the write bank's valid flag
//   i_fill_done     set the write bank's valid flag (wins over fill_start)
//   i_wr_column     write word address
//   i_wr_data       packed pixels, pixel k at [k*P +: P], red in the LSBs
//   i_wr_valid      write strobe into the write bank
//   i_pixel_first   first visible pixel of the line (ce-qualified)
//   i_pixel_last    last visible pixel of the line (ce-qualified)
//   i_blank         timing blank (ce-qualified)
//   i_clear_status  clear the sticky underrun flag
//   o_red/green/blue  pixel colour
//   o_pixel_valid   outputs carry active-line pixels
//   o_wr_bank       bank currently being written
//   o_underrun      sticky underrun flag
// ============================================================================
module video_line_buffer_pp #(
    parameter int COLOR_BITS      = 4,
    parameter int PIXELS_PER_WORD = 2,
    parameter int ADDR_BITS       = 9,
    parameter logic [3*COLOR_BITS-1:0] BLANK_RGB =
        {{(2*COLOR_BITS){1'b0}}, {COLOR_BITS{1'b1}}}
) (
    input  logic                                    i_master_clk,
    input  logic                                    i_reset_n,
    input  logic                                    i_pixel_ce,
    input  logic [1:0]                              i_scale_mode,
    input  logic                                    i_line_swap,
    input  logic                                    i_fill_start,
    input  logic                                    i_fill_done,
    input  logic [ADDR_BITS-1:0]                    i_wr_column,
    input  logic [3*COLOR_BITS*PIXELS_PER_WORD-1:0] i_wr_data,
    input  logic                                    i_wr_valid,
    input  logic                                    i_pixel_first,
    input  logic                                    i_pixel_last,
    input  logic                                    i_blank,
    input  logic                                    i_clear_status,
    output logic [COLOR_BITS-1:0]                   o_red,
    output logic [COLOR_BITS-1:0]                   o_green,
    output logic [COLOR_BITS-1:0]                   o_blue,
    output logic                                    o_pixel_valid,
    output logic                                    o_wr_bank,
    output logic                                    o_underrun
);

    localparam int P     = 3 * COLOR_BITS;
    localparam int W     = P * PIXELS_PER_WORD;
    localparam int S     = $clog2(PIXELS_PER_WORD);
    localparam int SUB_W = (S == 0) ? 1 : S;
    localparam int CNT_W = ADDR_BITS + S + 1;
    localparam int DEPTH = 2 ** (ADDR_BITS + 1);

    typedef enum logic [1:0] {
        MODE_BLANK  = 2'd0,
        MODE_NATIVE = 2'd1,
        MODE_DOUBLE = 2'd2,
        MODE_RSVD   = 2'd3
    } scale_mode_e;

    // Both banks share one array; the bank index is the top address bit.
    logic [W-1:0]       r_mem [DEPTH];

    logic               r_wr_bank;
    logic [1:0]         r_bank_valid;
    logic               r_swap_pend;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_active;
    logic               r_line_ur;
    logic               r_underrun;

    // Stage 0: per-pixel attributes captured with the counter.
    logic               r_s0_valid;
    logic               r_s0_blank;
    logic               r_s0_bank;
    // Stage 1: memory word plus delayed attributes.
    logic [W-1:0]       r_s1_word;
    logic [SUB_W-1:0]   r_s1_sub;
    logic               r_s1_blank;
    logic               r_s1_valid;
    logic               r_s1_ur;

    scale_mode_e        w_mode;
    logic               w_mode_on;
    logic               w_double;
    logic               w_rd_bank;
    logic               w_swap_now;
    logic               w_fill_bank;
    logic               w_ur_event;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic [SUB_W-1:0]   w_sub;
    logic [P-1:0]       w_pixel;

    assign w_mode    = scale_mode_e'(i_scale_mode);
    assign w_double  = (w_mode == MODE_DOUBLE);
    assign w_mode_on = (w_mode == MODE_NATIVE) || w_double;
    assign w_rd_bank = ~r_wr_bank;

    // A swap requested mid-line waits until the line has ended; a request
    // arriving while idle takes effect on this very edge.
    assign w_swap_now  = ~r_active & (r_swap_pend | i_line_swap);
    // Fill flags target the bank that is the write bank after this edge.
    assign w_fill_bank = w_swap_now ? ~r_wr_bank : r_wr_bank;

    assign w_ur_event = i_pixel_ce & i_pixel_first & w_mode_on
                      & ~r_bank_valid[w_rd_bank];

    // Doubling halves the counter before the word/sub-pixel split; the casts
    // drop address bits beyond the bank size.
    assign w_rd_addr = ADDR_BITS'(w_double ? (r_cnt >> (S + 1)) : (r_cnt >> S));
    assign w_sub     = SUB_W'(w_double ? (r_cnt >> 1) : r_cnt)
                     & SUB_W'(PIXELS_PER_WORD - 1);
    assign w_pixel   = r_s1_word[r_s1_sub * P +: P];

    // NOTE: the pixel memory has no reset; its content is only meaningful
    // after a fill, and a reset term would prevent RAM inference.
    always_ff @(posedge i_master_clk) begin
        if (i_wr_valid)
            r_mem[{r_wr_bank, i_wr_column}] <= i_wr_data;
        if (i_pixel_ce)
            r_s1_word <= r_mem[{r_s0_bank, w_rd_addr}];
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_bank     <= 1'b1;
            r_bank_valid  <= 2'b00;
            r_swap_pend   <= 1'b0;
            r_cnt         <= '0;
            r_active      <= 1'b0;
            r_line_ur     <= 1'b0;
            r_underrun    <= 1'b0;
            r_s0_valid    <= 1'b0;
            r_s0_blank    <= 1'b0;
            r_s0_bank     <= 1'b0;
            r_s1_sub      <= '0;
            r_s1_blank    <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_ur       <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_pixel_valid <= 1'b0;
        end else begin
            if (w_swap_now) begin
                r_wr_bank   <= ~r_wr_bank;
                r_swap_pend <= 1'b0;
            end else if (i_line_swap) begin
                // Only reachable mid-line; a repeat request is absorbed.
                r_swap_pend <= 1'b1;
            end

            if (i_fill_done)
                r_bank_valid[w_fill_bank] <= 1'b1;
            else if (i_fill_start)
                r_bank_valid[w_fill_bank] <= 1'b0;

            if (w_ur_event)
                r_underrun <= 1'b1;
            else if (i_clear_status)
                r_underrun <= 1'b0;

            if (i_pixel_ce) begin
                // Counter/active: r_active means "more pixels follow", so the
                // pixel sampled with i_pixel_last is still marked valid.
                if (i_pixel_first) begin
                    r_cnt     <= '0;
                    r_active  <= ~i_pixel_last;
                    r_line_ur <= w_mode_on & ~r_bank_valid[w_rd_bank];
                end else begin
                    if (r_active)
                        r_cnt <= r_cnt + CNT_W'(1);
                    if (i_pixel_last)
                        r_active <= 1'b0;
                end
                r_s0_valid <= i_pixel_first | r_active;
                r_s0_blank <= i_blank;
                // The bank travels with each pixel so a swap applied right
                // after the line cannot redirect its last reads.
                r_s0_bank  <= w_rd_bank;

                r_s1_sub   <= w_sub;
                r_s1_blank <= r_s0_blank;
                r_s1_valid <= r_s0_valid;
                r_s1_ur    <= r_line_ur;

                if (r_s1_blank || !w_mode_on || r_s1_ur)
                    {o_blue, o_green, o_red} <= BLANK_RGB;
                else
                    {o_blue, o_green, o_red} <= w_pixel;
                o_pixel_valid <= r_s1_valid;
            end
        end
    end

    assign o_wr_bank  = r_wr_bank;
    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_video_line_buffer_pp.sv
// ============================================================================
// tb_video_line_buffer_pp
// ----------------------------------------------------------------------------
// Directed stimulus for video_line_buffer_pp (C=4, PPW=2). Stimulus tasks push
// the expected colour of every visible pixel into a queue; a monitor pops and
// compares on each ce edge where o_pixel_valid is high, and checks that the
// outputs hold on edges without a ce.
// ============================================================================
module tb_video_line_buffer_pp;

    localparam int C = 4;
    localparam int P = 3 * C;
    localparam int A = 9;
    localparam logic [P-1:0] BLANK = 12'h00F;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_pixel_ce, i_line_swap, i_fill_start, i_fill_done;
    logic [1:0]     i_scale_mode;
    logic [A-1:0]   i_wr_column;
    logic [2*P-1:0] i_wr_data;
    logic           i_wr_valid, i_pixel_first, i_pixel_last, i_blank;
    logic           i_clear_status;
    logic [C-1:0]   o_red, o_green, o_blue;
    logic           o_pixel_valid, o_wr_bank, o_underrun;

    always #5 clk = ~clk;

    video_line_buffer_pp #(
        .COLOR_BITS(C), .PIXELS_PER_WORD(2), .ADDR_BITS(A)
    ) dut (
        .i_master_clk  (clk),
        .i_reset_n     (rst_n),
        .i_pixel_ce    (i_pixel_ce),
        .i_scale_mode  (i_scale_mode),
        .i_line_swap   (i_line_swap),
        .i_fill_start  (i_fill_start),
        .i_fill_done   (i_fill_done),
        .i_wr_column   (i_wr_column),
        .i_wr_data     (i_wr_data),
        .i_wr_valid    (i_wr_valid),
        .i_pixel_first (i_pixel_first),
        .i_pixel_last  (i_pixel_last),
        .i_blank       (i_blank),
        .i_clear_status(i_clear_status),
        .o_red         (o_red),
        .o_green       (o_green),
        .o_blue        (o_blue),
        .o_pixel_valid (o_pixel_valid),
        .o_wr_bank     (o_wr_bank),
        .o_underrun    (o_underrun)
    );

    typedef struct packed {
        logic [P-1:0] rgb;
        logic         first;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           ce_cnt = 0;
    int           first_ce = 0;
    logic         edge_ce = 1'b0;
    logic         mon_en = 1'b0;
    logic [P-1:0] last_rgb = '0;
    logic         last_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Test pixel n: red = 3n, green = 3n+1, blue = 3n+2 (mod 16).
    function automatic logic [P-1:0] pix(input int n);
        logic [C-1:0] r, g, b;
        r = C'(3 * n);
        g = C'(3 * n + 1);
        b = C'(3 * n + 2);
        return {b, g, r};
    endfunction

    // Edge bookkeeping for the monitor.
    always @(posedge clk) begin
        edge_ce <= i_pixel_ce && rst_n;
        if (i_pixel_ce && rst_n) begin
            ce_cnt <= ce_cnt + 1;
            if (i_pixel_first)
                first_ce <= ce_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [P-1:0] rgb;
        exp_t         e;
        rgb = {o_blue, o_green, o_red};
        if (mon_en) begin
            if (edge_ce) begin
                if (o_pixel_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel: got %0h expected none at %0t",
                                 rgb, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel_rgb", 32'(rgb), 32'(e.rgb));
                        if (e.first)
                            check("first_latency", 32'(ce_cnt - first_ce), 32'd2);
                    end
                end
            end else begin
                check("hold_rgb", 32'(rgb), 32'(last_rgb));
                check("hold_valid", 32'(o_pixel_valid), 32'(last_valid));
            end
        end
        last_rgb   = rgb;
        last_valid = o_pixel_valid;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_swap();
        i_line_swap = 1'b1;
        tick();
        i_line_swap = 1'b0;
    endtask

    task automatic write_word(input int addr, input logic [2*P-1:0] data);
        i_wr_column = A'(addr);
        i_wr_data   = data;
        i_wr_valid  = 1'b1;
        tick();
        i_wr_valid  = 1'b0;
    endtask

    // Words 0..3 of the write bank get pixels off+0 .. off+7.
    task automatic fill_bank(input int off);
        i_fill_start = 1'b1;
        tick();
        i_fill_start = 1'b0;
        for (int k = 0; k < 4; k++)
            write_word(k, {pix(off + 2*k + 1), pix(off + 2*k)});
        i_fill_done = 1'b1;
        tick();
        i_fill_done = 1'b0;
    endtask

    // Drive an n-pixel line, one ce every `duty` clocks; push expectations.
    task automatic drive_line(input int n, input int duty, input int blank_lo,
                              input int blank_hi, input int swap_at,
                              input bit exp_ur, input int off);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            i_pixel_ce    = 1'b1;
            i_pixel_first = (i == 0);
            i_pixel_last  = (i == n - 1);
            i_blank       = (i >= blank_lo) && (i <= blank_hi);
            i_line_swap   = (i == swap_at);
            if (i_blank || exp_ur || i_scale_mode == 2'd0 || i_scale_mode == 2'd3)
                e.rgb = BLANK;
            else if (i_scale_mode == 2'd2)
                e.rgb = pix(off + (i >> 1));
            else
                e.rgb = pix(off + i);
            e.first = (i == 0);
            exp_q.push_back(e);
            tick();
            i_pixel_first = 1'b0;
            i_pixel_last  = 1'b0;
            i_blank       = 1'b0;
            i_line_swap   = 1'b0;
            for (int d = 1; d < duty; d++) begin
                i_pixel_ce = 1'b0;
                tick();
            end
        end
        i_pixel_ce = 1'b0;
    endtask

    task automatic drain();
        i_pixel_ce = 1'b1;
        repeat (4) tick();
        i_pixel_ce = 1'b0;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++)
            tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_pixel_ce = 1'b0; i_scale_mode = 2'd1; i_line_swap = 1'b0;
        i_fill_start = 1'b0; i_fill_done = 1'b0; i_wr_column = '0;
        i_wr_data = '0; i_wr_valid = 1'b0; i_pixel_first = 1'b0;
        i_pixel_last = 1'b0; i_blank = 1'b0; i_clear_status = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_rgb", 32'({o_blue, o_green, o_red}), 32'd0);
        check("rst_valid", 32'(o_pixel_valid), 32'd0);
        check("rst_wr_bank", 32'(o_wr_bank), 32'd1);
        check("rst_underrun", 32'(o_underrun), 32'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Fill bank 1, swap while idle: bank 1 becomes the read bank.
        fill_bank(0);
        pulse_swap();
        check("swap_idle_wr_bank", 32'(o_wr_bank), 32'd0);

        // Native mode, then 2x doubling from the same data.
        i_scale_mode = 2'd1;
        drive_line(8, 1, -1, -1, -1, 1'b0, 0);
        drain();
        i_scale_mode = 2'd2;
        drive_line(8, 1, -1, -1, -1, 1'b0, 0);
        drain();

        // Fill bank 0 with different data, then request a swap mid-line.
        fill_bank(8);
        i_scale_mode = 2'd1;
        drive_line(8, 1, -1, -1, 3, 1'b0, 0);
        check("swap_pending_wr_bank", 32'(o_wr_bank), 32'd0);
        tick();
        check("swap_applied_wr_bank", 32'(o_wr_bank), 32'd1);
        drain();

        // The line after the swap reads bank 0.
        drive_line(8, 1, -1, -1, -1, 1'b0, 8);
        drain();

        // Mode 0 blanks everything and does not flag an underrun.
        i_scale_mode = 2'd0;
        drive_line(4, 1, -1, -1, -1, 1'b0, 8);
        drain();
        check("mode0_no_underrun", 32'(o_underrun), 32'd0);
        i_scale_mode = 2'd1;

        // Underrun: invalidate bank 1 and swap it to the read side.
        i_fill_start = 1'b1;
        tick();
        i_fill_start = 1'b0;
        pulse_swap();
        check("ur_wr_bank", 32'(o_wr_bank), 32'd0);
        drive_line(8, 1, -1, -1, -1, 1'b1, 0);
        drain();
        check("underrun_set", 32'(o_underrun), 32'd1);
        i_clear_status = 1'b1;
        tick();
        i_clear_status = 1'b0;
        check("underrun_cleared", 32'(o_underrun), 32'd0);

        // ce duty 1/3 with blank over pixels 2..3, reading bank 0.
        i_fill_done = 1'b1;
        tick();
        i_fill_done = 1'b0;
        pulse_swap();
        check("duty_wr_bank", 32'(o_wr_bank), 32'd1);
        drive_line(8, 3, 2, 3, -1, 1'b0, 8);
        drain();

        // Reset in the middle of a line.
        pulse_swap();
        check("pre_reset_wr_bank", 32'(o_wr_bank), 32'd0);
        mon_en = 1'b0;
        i_pixel_ce = 1'b1;
        i_pixel_first = 1'b1;
        tick();
        i_pixel_first = 1'b0;
        repeat (3) tick();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rgb", 32'({o_blue, o_green, o_red}), 32'd0);
        check("midrst_valid", 32'(o_pixel_valid), 32'd0);
        check("midrst_wr_bank", 32'(o_wr_bank), 32'd1);
        check("midrst_underrun", 32'(o_underrun), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("aborted_line_valid", 32'(o_pixel_valid), 32'd0);
        i_pixel_ce = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
